encrypted_packetizer: RTL and testbench



---
 rtl/encrypted_packetizer_pkg.sv | 28 ++
 rtl/encrypted_packetizer_usb_crc16.sv | 25 ++
 rtl/encrypted_packetizer.sv | 153 +++++++++++++++
 tb/tb_encrypted_packetizer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encrypted_packetizer_pkg.sv
// Shared types and constants for the encrypted packetizer.
// The CRC helper is only used when ENCRYPTED_PACKETIZER_CRC16_EN is defined.
package encrypted_packetizer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        CRC_LO,
        CRC_HI,
        EOP,
        GAP
    } state_t;

    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
    localparam int unsigned USB_FS_BULK_MAX = 64;

    // One byte of reflected CRC-16/USB, LSB first.
    function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/encrypted_packetizer_usb_crc16.sv
// Byte-wide CRC-16/USB accumulator (raw register, not inverted).
// Used by encrypted_packetizer only when ENCRYPTED_PACKETIZER_CRC16_EN is defined.
module usb_crc16
    import encrypted_packetizer_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    // Clear wins over update so a packet boundary always restarts from the seed.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc <= CRC16_INIT;
        end else if (clear) begin
            crc <= CRC16_INIT;
        end else if (en) begin
            crc <= crc16_update(crc, data);
        end
    end

endmodule

// File: rtl/encrypted_packetizer.sv
// Frames ciphertext bytes from a fall-through FIFO into USB bulk-IN packets.
// Optional CRC-16 trailer: define ENCRYPTED_PACKETIZER_CRC16_EN.
// GAP_CYCLES must be at least 1.
module encrypted_packetizer
    import encrypted_packetizer_pkg::*;
#(
    parameter int unsigned PKT_BYTES  = USB_FS_BULK_MAX,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_r_data,
    output logic       fifo_r_enable,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       tx_eop,
    output logic       pkt_sent,
    output logic       busy
);

    localparam int unsigned BCW = $clog2(PKT_BYTES + 1);
    localparam int unsigned TCW = $clog2(TIMEOUT + 1);
    localparam int unsigned GCW = $clog2(GAP_CYCLES + 1);

    localparam logic [BCW-1:0] BYTE_MAX = BCW'(PKT_BYTES);
    localparam logic [TCW-1:0] TO_MAX   = TCW'(TIMEOUT);
    localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_CYCLES - 1);

    state_t         state;
    logic [BCW-1:0] byte_cnt;
    logic [TCW-1:0] to_cnt;
    logic [GCW-1:0] gap_cnt;
    logic           slot_free;
    logic           close;

    // The single output register can take a new beat when empty or draining this cycle.
    assign slot_free = !tx_valid || tx_ready;

    assign fifo_r_enable = (state == SEND) && !fifo_empty && slot_free && (byte_cnt < BYTE_MAX);

    // A pop always beats a close, so a byte arriving on the timeout cycle is kept.
    assign close = (state == SEND) && (byte_cnt != '0) && slot_free && !fifo_r_enable &&
                   ((byte_cnt == BYTE_MAX) || (to_cnt == TO_MAX));

    assign busy = (state != IDLE);

`ifdef ENCRYPTED_PACKETIZER_CRC16_EN
    logic [15:0] crc;
    logic        crc_clear;

    assign crc_clear = (state == EOP) && tx_ready;

    usb_crc16 u_crc (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (crc_clear),
        .en    (fifo_r_enable),
        .data  (fifo_r_data),
        .crc   (crc)
    );
`endif

    // Packet FSM with registered beat, counters and pkt_sent pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            byte_cnt <= '0;
            to_cnt   <= '0;
            gap_cnt  <= '0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            tx_eop   <= 1'b0;
            pkt_sent <= 1'b0;
        end else begin
            pkt_sent <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (fifo_r_enable) begin
                        tx_data  <= fifo_r_data;
                        tx_valid <= 1'b1;
                        tx_eop   <= 1'b0;
                        byte_cnt <= byte_cnt + BCW'(1);
                        to_cnt   <= '0;
                    end else if (close) begin
                        tx_valid <= 1'b1;
`ifdef ENCRYPTED_PACKETIZER_CRC16_EN
                        tx_data  <= ~crc[7:0];
                        tx_eop   <= 1'b0;
                        state    <= CRC_LO;
`else
                        tx_data  <= 8'h00;
                        tx_eop   <= 1'b1;
                        state    <= EOP;
`endif
                    end else begin
                        if (tx_valid && tx_ready) begin
                            tx_valid <= 1'b0;
                        end
                        if (fifo_empty && (byte_cnt != '0) && (to_cnt != TO_MAX)) begin
                            to_cnt <= to_cnt + TCW'(1);
                        end
                    end
                end
`ifdef ENCRYPTED_PACKETIZER_CRC16_EN
                CRC_LO: begin
                    if (tx_ready) begin
                        tx_data <= ~crc[15:8];
                        state   <= CRC_HI;
                    end
                end
                CRC_HI: begin
                    if (tx_ready) begin
                        tx_data <= 8'h00;
                        tx_eop  <= 1'b1;
                        state   <= EOP;
                    end
                end
`endif
                EOP: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        tx_eop   <= 1'b0;
                        pkt_sent <= 1'b1;
                        byte_cnt <= '0;
                        to_cnt   <= '0;
                        gap_cnt  <= '0;
                        state    <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GCW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encrypted_packetizer.sv
// Scoreboard bench for encrypted_packetizer; honours ENCRYPTED_PACKETIZER_CRC16_EN.
module tb_encrypted_packetizer;

    localparam int PKT = 64;
    localparam int TO  = 16;
    localparam int GAP = 4;
`ifdef ENCRYPTED_PACKETIZER_CRC16_EN
    localparam int CRCB = 2;
`else
    localparam int CRCB = 0;
`endif

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_r_data = 8'h00;
    logic       fifo_r_enable;
    logic       tx_ready = 1'b0;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_eop;
    logic       pkt_sent;
    logic       busy;

    encrypted_packetizer #(
        .PKT_BYTES  (PKT),
        .TIMEOUT    (TO),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .fifo_empty    (fifo_empty),
        .fifo_r_data   (fifo_r_data),
        .fifo_r_enable (fifo_r_enable),
        .tx_ready      (tx_ready),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_eop        (tx_eop),
        .pkt_sent      (pkt_sent),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] push_q[$];
    logic [8:0] exp_q[$];
    int         ready_mode = 0;
    int         pat_idx = 0;
    int         pop_cnt = 0;
    int         pkt_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    // Reference CRC-16/USB, one bit at a time, returned already inverted.
    function automatic logic [15:0] ref_crc(input logic [7:0] b[$]);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (b[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return ~c;
    endfunction

    // Expected beats for a stream that arrives without long stalls: chunks of PKT bytes.
    task automatic expect_stream(input logic [7:0] b[$], output int npk);
        logic [7:0]  pkt[$];
        logic [15:0] c;
        int          i;
        i   = 0;
        npk = 0;
        while (i < b.size()) begin
            pkt = {};
            while (i < b.size() && pkt.size() < PKT) begin
                pkt.push_back(b[i]);
                i++;
            end
            foreach (pkt[j]) exp_q.push_back({1'b0, pkt[j]});
            c = ref_crc(pkt);
            if (CRCB != 0) begin
                exp_q.push_back({1'b0, c[7:0]});
                exp_q.push_back({1'b0, c[15:8]});
            end
            exp_q.push_back(9'h100);
            npk++;
        end
    endtask

    // Fall-through FIFO model owned by one process.
    always @(posedge clk) begin
        if (fifo_r_enable && fifo_q.size() > 0) void'(fifo_q.pop_front());
        while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
        fifo_empty  <= (fifo_q.size() == 0);
        fifo_r_data <= (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end

    // Sink back-pressure: always ready, random, or the 1,0,0,1 pattern.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = 1'($urandom_range(0, 1));
            default: begin
                tx_ready = (pat_idx == 0) || (pat_idx == 3);
                pat_idx  = (pat_idx + 1) % 4;
            end
        endcase
    end

    // Monitor: pops expected beats on every transfer and checks handshake rules.
    logic       prev_stall = 1'b0;
    logic [8:0] prev_beat = '0;
    logic       prev_eop_xfer = 1'b0;
    logic       after_eop = 1'b0;
    int         idle_run = 0;
    logic [8:0] mon_exp;

    always @(negedge clk) begin
        if (!n_rst) begin
            prev_stall    = 1'b0;
            prev_eop_xfer = 1'b0;
            after_eop     = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(tx_valid), 32'd1);
                check("hold_beat", 32'({tx_eop, tx_data}), 32'(prev_beat));
            end
            if (prev_eop_xfer || pkt_sent) check("pkt_sent", 32'(pkt_sent), 32'(prev_eop_xfer));
            if (pkt_sent) pkt_cnt++;
            if (fifo_r_enable) pop_cnt++;
            if (after_eop) begin
                if (tx_valid) begin
                    check_range("eop_gap_idle", idle_run, GAP, 1 << 30);
                    after_eop = 1'b0;
                end else begin
                    idle_run++;
                end
            end
            prev_stall    = tx_valid && !tx_ready;
            prev_beat     = {tx_eop, tx_data};
            prev_eop_xfer = tx_valid && tx_ready && tx_eop;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL beat: unexpected beat eop=%0b data=0x%0h, expected none", tx_eop,
                             tx_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("beat", 32'({tx_eop, tx_data}), 32'(mon_exp));
                end
                if (tx_eop) begin
                    after_eop = 1'b1;
                    idle_run  = 0;
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_tx_eop"}, 32'(tx_eop), 32'd0);
        check({tag, "_pkt_sent"}, 32'(pkt_sent), 32'd0);
        check({tag, "_fifo_r_enable"}, 32'(fifo_r_enable), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic run_session(input logic [7:0] b[$], input bit preload, input int mode);
        int pops0, pk0, npk, n;
        ready_mode = mode;
        pops0      = pop_cnt;
        pk0        = pkt_cnt;
        expect_stream(b, npk);
        if (preload) begin
            foreach (b[i]) push_q.push_back(b[i]);
        end else begin
            foreach (b[i]) begin
                push_q.push_back(b[i]);
                repeat (1 + $urandom_range(0, 6)) @(negedge clk);
            end
        end
        n = 0;
        while ((exp_q.size() != 0 || push_q.size() != 0 || !fifo_empty) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d beats still outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (GAP + 4) @(negedge clk);
        check("busy_after", 32'(busy), 32'd0);
        check("valid_after", 32'(tx_valid), 32'd0);
        check("pop_count", 32'(pop_cnt - pops0), 32'(b.size()));
        check("pkt_sent_count", 32'(pkt_cnt - pk0), 32'(npk));
    endtask

    task automatic measure_timeout();
        int n;
        n = 0;
        while (fifo_empty && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (!fifo_empty && n < 200) begin @(negedge clk); n++; end
        n = 0;
        while (!(tx_valid && tx_eop) && n < 200) begin @(negedge clk); n++; end
        check_range("timeout_eop_delay", n, TO + CRCB, TO + CRCB + 2);
    endtask

    logic [7:0] bytes[$];

    initial begin
        #3;
        check_all_zero("reset");
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // Full packet, in order.
        bytes = {};
        for (int i = 0; i < 64; i++) bytes.push_back(8'(i));
        run_session(bytes, 1'b1, 0);

        // Short packet closed by timeout.
        bytes = {};
        for (int i = 0; i < 5; i++) bytes.push_back(8'(8'hA0 + i));
        fork
            run_session(bytes, 1'b1, 0);
            measure_timeout();
        join

        // Back-pressure 1,0,0,1.
        bytes = {};
        for (int i = 0; i < 20; i++) bytes.push_back(8'($urandom));
        run_session(bytes, 1'b1, 2);

        // Split into 64 + 64 + 2.
        bytes = {};
        for (int i = 0; i < 130; i++) bytes.push_back(8'($urandom));
        run_session(bytes, 1'b1, 0);

        // "123456789"; carries C8, B4 when CRC is enabled.
        bytes = {};
        for (int i = 0; i < 9; i++) bytes.push_back(8'(8'h31 + i));
        run_session(bytes, 1'b1, 0);

        // Reset mid-packet after 10 bytes, then a fresh 3-byte packet.
        ready_mode = 0;
        pop_cnt    = 0;
        for (int i = 0; i < 10; i++) begin
            push_q.push_back(8'(8'h50 + i));
            exp_q.push_back({1'b0, 8'(8'h50 + i)});
        end
        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
            check("reset_pre_beats_left", 32'(exp_q.size()), 32'd0);
        end
        repeat (2) @(negedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        check_all_zero("midreset");
        check("midreset_pops", 32'(pop_cnt), 32'd10);
        exp_q.delete();
        @(negedge clk);
        #2;
        n_rst = 1'b1;
        bytes = {};
        for (int i = 0; i < 3; i++) bytes.push_back(8'(8'hC0 + i));
        run_session(bytes, 1'b1, 0);

        // Randomised sessions, trickled or preloaded, assorted back-pressure.
        for (int s = 0; s < 6; s++) begin
            int len;
            len   = int'($urandom_range(1, 150));
            bytes = {};
            for (int i = 0; i < len; i++) bytes.push_back(8'($urandom));
            run_session(bytes, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
